p1v_board_io: RTL and testbench
===============================

# p1v_board_io

Parametrised board I/O adapter between the FPGA pads and the `p1v` core, replacing per-board hand-written glue. It synchronises pad inputs, gates pad output enables, debounces and stretches the external reset into the core's `inp_resn`, and drives active-low board LEDs from per-cog activity with an optional visibility stretch. The top level keeps only the pad tristate buffers: `pad = pad_oe ? pad_out : 'z`.

## Interface
Parameters:
- `PINS`, 32: pad/port count.
- `COGS`, 8: cog LED inputs.
- `LEDS`, 16: board LEDs.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.
- `RESET_FILTER`, 16: consecutive synced cycles needed to accept a reset edge, ≥1.
- `RESET_STRETCH`, 1024: extra cycles the core is held in reset after release is accepted, ≥1.
- `LED_HOLD_BITS`, 20: width of the per-cog LED stretch counter.

Ports:
- `clock_160` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `ext_resn_in` in 1: raw external reset from USB serial, active-low, asynchronous.
- `p1v_resn` out 1: to core `inp_resn`, registered.
- `pin_out` in PINS: core output values.
- `pin_dir` in PINS: core directions, 1 = drive.
- `pin_in` out PINS: synchronised pad values to the core.
- `pad_in` in PINS: raw pad values.
- `pad_out` out PINS: value driven to pads.
- `pad_oe` out PINS: pad output enable.
- `cog_led` in COGS: core cog-active flags.
- `led` out LEDS: board LEDs, 0 = lit.

## Operation
- Reset values: all synchroniser flops 0; `p1v_resn` 0; FSM HOLD; counters 0; `led` all 1; `pin_in` 0.
- `pin_in` = `pad_in` through SYNC_STAGES flops per bit.
- `pad_out` = `pin_out`, combinational. `pad_oe` = `pin_dir & {PINS{p1v_resn}}`: all pads tristate while the core is in reset.
- `ext_resn_in` passes through SYNC_STAGES flops to `rs`. The reset FSM states are:
  - HOLD (`p1v_resn`=0): `rs`=1 → DEBOUNCE, count restarts.
  - DEBOUNCE (0): `rs`=0 → HOLD. After RESET_FILTER consecutive highs → STRETCH.
  - STRETCH (0): `rs`=0 → HOLD. After RESET_STRETCH cycles → RUN.
  - RUN (1): `rs`=0 → ARM, count restarts.
  - ARM (1): `rs`=1 → RUN. After RESET_FILTER consecutive lows → HOLD.
- LED activity, per cog i: `act[i]` = `cog_led[i]` | (cnt[i]≠0). Each counter reloads to all-ones while `cog_led[i]`=1, otherwise decrements and saturates at 0.
- LED mapping, registered: `led[i]` = ~`act[i]` (lit when active); `led[COGS+i]` = `act[i]` (lit when idle). Indices ≥2·COGS are driven 1; mappings past LEDS-1 are dropped.

## Timing
- Counter widths are `$clog2(max+1)`. No counter wraps; all saturate or reload.
- `pin_in` latency: SYNC_STAGES cycles.
- Release latency: with `ext_resn_in` steady high, `p1v_resn` first reads 1 after edge SYNC_STAGES+RESET_FILTER+RESET_STRETCH+1, counting edge 1 as the first edge with `reset`=0.
- Assert latency: `p1v_resn` reads 0 SYNC_STAGES+RESET_FILTER edges after `ext_resn_in` falls.
- Low pulses shorter than RESET_FILTER cycles in RUN are ignored.
- Any low in DEBOUNCE or STRETCH restarts the whole release sequence.
- `reset` mid-operation: next edge forces HOLD, `p1v_resn`=0 and `pad_oe`=0. This takes priority over all FSM transitions.
- LED path: one cycle from `cog_led` to `led`. With the stretch feature, activity persists 2^LED_HOLD_BITS−1 cycles after `cog_led` falls.

## Configuration
- Macro: `P1V_LED_STRETCH_EN`.
- Defined: per-cog stretch counters as above.
- Undefined: no counters, and `act[i]` = `cog_led[i]`. The LED register and its one-cycle latency are unchanged.

## Structure
- Package `p1v_board_pkg` holds the reset FSM state enum (HOLD, DEBOUNCE, STRETCH, RUN, ARM) and the parameter defaults as localparams.
- Sub-module `p1v_reset_filter` contains the `ext_resn_in` synchroniser, the FSM and the counter, and outputs `p1v_resn`.
- Pin synchronisers, `pad_oe` gating and the LED logic stay in `p1v_board_io`.

## Test plan
Bench overrides: SYNC_STAGES=2, RESET_FILTER=4, RESET_STRETCH=8, LED_HOLD_BITS=3, COGS=8, LEDS=16.
- **Release:** `reset` high 3 cycles then low, `ext_resn_in`=1 → `p1v_resn` reads 1 from edge 15. Before that, `pad_oe`=0 even with `pin_dir`=FFFF_FFFF.
- **Glitch rejection:** in RUN, `ext_resn_in` low 3 cycles → `p1v_resn` stays 1. Low 4 cycles → `p1v_resn`=0 six edges after the fall, and `pad_oe` goes 0 in the same cycle.
- **Restart:** `ext_resn_in` low for 1 cycle during STRETCH → release completes 14 edges after the low ends, never earlier.
- **Pins:** `pin_dir`=0000_00FF, `pin_out`=0000_00A5 in RUN → `pad_oe`=0000_00FF, `pad_out`=0000_00A5. A `pad_in` step to 1234_5678 appears on `pin_in` 2 cycles later.
- **LED stretch:** `cog_led`=0x01 for one cycle.
  - With `P1V_LED_STRETCH_EN`: `led[0]`=0 and `led[8]`=1 for 8 cycles, then `led[0]`=1.
  - Without it: `led[0]`=0 for exactly 1 cycle.
- **Mid-run reset:** `reset` asserted in RUN → `p1v_resn`=0 and `led`=FFFF at the next edge. After release, the full 15-edge release sequence repeats.

Source files
------------

// File: rtl/p1v_board_pkg.sv
// rtl/p1v_board_pkg.sv - shared reset FSM states and default parameters for the p1v board adapter
package p1v_board_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DEBOUNCE,
    ST_STRETCH,
    ST_RUN,
    ST_ARM
  } rst_state_e;

  localparam int DEF_PINS          = 32;
  localparam int DEF_COGS          = 8;
  localparam int DEF_LEDS          = 16;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_RESET_FILTER  = 16;
  localparam int DEF_RESET_STRETCH = 1024;
  localparam int DEF_LED_HOLD_BITS = 20;

endpackage

// File: rtl/p1v_reset_filter.sv
// rtl/p1v_reset_filter.sv - synchronises, debounces and stretches the external reset into p1v_resn
module p1v_reset_filter
  import p1v_board_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RESET_FILTER  = DEF_RESET_FILTER,
  parameter int RESET_STRETCH = DEF_RESET_STRETCH
) (
  input  logic clock_160,
  input  logic reset,
  input  logic ext_resn_in,
  output logic p1v_resn
);

  localparam int CNT_MAX = (RESET_FILTER > RESET_STRETCH) ? RESET_FILTER : RESET_STRETCH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(RESET_FILTER - 1);
  localparam logic [CW-1:0] STR_LAST  = CW'(RESET_STRETCH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs;
  rst_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   resn_q;

  assign rs = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (rs) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!rs) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STRETCH: begin
        if (!rs) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STR_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        // The low seen here is the first of the RESET_FILTER lows needed to drop out of RUN.
        if (!rs) begin
          state_d = (RESET_FILTER == 1) ? ST_HOLD : ST_ARM;
          cnt_d   = (RESET_FILTER == 1) ? '0 : CW'(1);
        end
      end
      ST_ARM: begin
        if (rs) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_160) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      resn_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_resn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resn_q  <= (state_d == ST_RUN) || (state_d == ST_ARM);
    end
  end

  assign p1v_resn = resn_q;

endmodule

// File: rtl/p1v_board_io.sv
// rtl/p1v_board_io.sv - pad/core adapter: pin sync, oe gating, reset filter, cog LEDs
// Optional per-cog LED visibility stretch enabled by P1V_LED_STRETCH_EN.
module p1v_board_io
  import p1v_board_pkg::*;
#(
  parameter int PINS          = DEF_PINS,
  parameter int COGS          = DEF_COGS,
  parameter int LEDS          = DEF_LEDS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RESET_FILTER  = DEF_RESET_FILTER,
  parameter int RESET_STRETCH = DEF_RESET_STRETCH,
  parameter int LED_HOLD_BITS = DEF_LED_HOLD_BITS
) (
  input  logic            clock_160,
  input  logic            reset,
  input  logic            ext_resn_in,
  output logic            p1v_resn,
  input  logic [PINS-1:0] pin_out,
  input  logic [PINS-1:0] pin_dir,
  output logic [PINS-1:0] pin_in,
  input  logic [PINS-1:0] pad_in,
  output logic [PINS-1:0] pad_out,
  output logic [PINS-1:0] pad_oe,
  input  logic [COGS-1:0] cog_led,
  output logic [LEDS-1:0] led
);

  logic [PINS-1:0] pin_sync_q [SYNC_STAGES];
  logic [COGS-1:0] act;
  logic [LEDS-1:0] led_q, led_d;

  p1v_reset_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .RESET_FILTER (RESET_FILTER),
    .RESET_STRETCH(RESET_STRETCH)
  ) u_reset_filter (
    .clock_160  (clock_160),
    .reset      (reset),
    .ext_resn_in(ext_resn_in),
    .p1v_resn   (p1v_resn)
  );

  always_ff @(posedge clock_160) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) pin_sync_q[s] <= '0;
    end else begin
      pin_sync_q[0] <= pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) pin_sync_q[s] <= pin_sync_q[s-1];
    end
  end

  assign pin_in  = pin_sync_q[SYNC_STAGES-1];
  assign pad_out = pin_out;
  // Core outputs must not fight the board while the core is held in reset.
  assign pad_oe  = pin_dir & {PINS{p1v_resn}};

`ifdef P1V_LED_STRETCH_EN
  logic [LED_HOLD_BITS-1:0] led_cnt_q [COGS];

  always_ff @(posedge clock_160) begin
    if (reset) begin
      for (int i = 0; i < COGS; i++) led_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < COGS; i++) begin
        if (cog_led[i])               led_cnt_q[i] <= '1;
        else if (led_cnt_q[i] != '0) led_cnt_q[i] <= led_cnt_q[i] - LED_HOLD_BITS'(1);
      end
    end
  end

  always_comb begin
    act = '0;
    for (int i = 0; i < COGS; i++) act[i] = cog_led[i] | (led_cnt_q[i] != '0);
  end
`else
  logic unused_led_hold;
  assign unused_led_hold = (LED_HOLD_BITS == 0);
  assign act = cog_led;
`endif

  always_comb begin
    led_d = '1;
    for (int i = 0; i < COGS; i++) begin
      if (i < LEDS)        led_d[i]        = ~act[i];
      if (COGS + i < LEDS) led_d[COGS + i] = act[i];
    end
  end

  always_ff @(posedge clock_160) begin
    if (reset) led_q <= '1;
    else       led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: tb/tb_p1v_board_io.sv
// tb/tb_p1v_board_io.sv - directed self-checking bench for p1v_board_io
module tb_p1v_board_io;

`ifdef P1V_LED_STRETCH_EN
  localparam int LED_ON_CYC = 8;
`else
  localparam int LED_ON_CYC = 1;
`endif
  localparam logic [31:0] LED_IDLE = 32'h0000_00FF;
  localparam logic [31:0] LED_ACT0 = 32'h0000_01FE;

  logic        clock_160 = 1'b0;
  logic        reset;
  logic        ext_resn_in;
  logic        p1v_resn;
  logic [31:0] pin_out, pin_dir, pin_in, pad_in, pad_out, pad_oe;
  logic [7:0]  cog_led;
  logic [15:0] led;

  int n_run  = 0;
  int n_fail = 0;

  p1v_board_io #(
    .PINS(32), .COGS(8), .LEDS(16), .SYNC_STAGES(2),
    .RESET_FILTER(4), .RESET_STRETCH(8), .LED_HOLD_BITS(3)
  ) dut (
    .clock_160  (clock_160),
    .reset      (reset),
    .ext_resn_in(ext_resn_in),
    .p1v_resn   (p1v_resn),
    .pin_out    (pin_out),
    .pin_dir    (pin_dir),
    .pin_in     (pin_in),
    .pad_in     (pad_in),
    .pad_out    (pad_out),
    .pad_oe     (pad_oe),
    .cog_led    (cog_led),
    .led        (led)
  );

  always #5 clock_160 = ~clock_160;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock_160);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    ext_resn_in = 1'b1;
    pin_dir     = 32'hFFFF_FFFF;
    pin_out     = 32'h0;
    pad_in      = 32'h0;
    cog_led     = 8'h0;

    repeat (3) step();
    chk("reset_resn", 32'(p1v_resn), 32'h0);
    chk("reset_pin_in", pin_in, 32'h0);
    chk("reset_led", 32'(led), 32'h0000_FFFF);
    chk("reset_oe", pad_oe, 32'h0);

    // release: p1v_resn first 1 at edge 15
    reset = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("release_resn", 32'(p1v_resn), (e == 15) ? 32'h1 : 32'h0);
      chk("release_oe", pad_oe, (e == 15) ? 32'hFFFF_FFFF : 32'h0);
    end
    chk("run_led_idle", 32'(led), LED_IDLE);

    // pins
    pin_dir = 32'h0000_00FF;
    pin_out = 32'h0000_00A5;
    #1;
    chk("pins_oe", pad_oe, 32'h0000_00FF);
    chk("pins_out", pad_out, 32'h0000_00A5);
    pad_in = 32'h1234_5678;
    step();
    chk("pin_in_lat1", pin_in, 32'h0);
    step();
    chk("pin_in_lat2", pin_in, 32'h1234_5678);

    // 3-cycle glitch is ignored
    ext_resn_in = 1'b0;
    repeat (3) step();
    ext_resn_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("glitch3_resn", 32'(p1v_resn), 32'h1);
    end

    // 4-cycle low asserts reset six edges after the fall
    ext_resn_in = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 4) ext_resn_in = 1'b1;
      chk("low4_resn", 32'(p1v_resn), (e < 6) ? 32'h1 : 32'h0);
      chk("low4_oe", pad_oe, (e < 6) ? 32'h0000_00FF : 32'h0);
    end
    begin
      int budget;
      budget = 0;
      while (p1v_resn !== 1'b1 && budget < 40) begin
        step();
        budget++;
      end
      chk("rerelease_timeout", 32'(budget < 40), 32'h1);
    end

    // LED activity for one cycle on cog 0
    step();
    cog_led = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      step();
      cog_led = 8'h00;
      chk("led_stretch", 32'(led), (c <= LED_ON_CYC) ? LED_ACT0 : LED_IDLE);
    end

    // mid-run reset
    chk("midrun_resn_before", 32'(p1v_resn), 32'h1);
    reset = 1'b1;
    step();
    chk("midrun_resn", 32'(p1v_resn), 32'h0);
    chk("midrun_led", 32'(led), 32'h0000_FFFF);
    chk("midrun_oe", pad_oe, 32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("midrun_release", 32'(p1v_resn), (e == 15) ? 32'h1 : 32'h0);
    end

    // one-cycle low during STRETCH restarts the release
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9) ext_resn_in = 1'b0;
      if (e == 10) ext_resn_in = 1'b1;
      chk("restart_pre", 32'(p1v_resn), 32'h0);
    end
    for (int n = 1; n <= 15; n++) begin
      step();
      chk("restart_release", 32'(p1v_resn), (n == 15) ? 32'h1 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
